// File: rtl/alarm_ctrl.sv
// Memory-mapped alarm responder: compares a programmed BCD alarm time against the
// live time once per second and sequences ring / snooze / dismiss for the buzzer.
module alarm_ctrl #(
  parameter int ADDRWIDTH = 4,
  parameter int SNOOZE_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic                 rd,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [31:0]          rdata,
  input  logic                 sec_tick,
  input  logic [23:0]          time_bcd,
  output logic                 ring,
  output logic [1:0]           alarm_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_ALARM  = 2'd1;
  localparam logic [1:0] A_SNZLEN = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  // Programmable registers and one-cycle command pulses.
  logic                en_q, en_d;
  logic [7:0]          ring_to_q, ring_to_d;
  logic [23:0]         alarm_time_q, alarm_time_d;
  logic [SNOOZE_W-1:0] snooze_len_q, snooze_len_d;
  logic                snz_req_q, snz_req_d;
  logic                dis_req_q, dis_req_d;
  logic                mclr_req_q, mclr_req_d;

  // FSM and its counters.
  state_t              state_q, state_d;
  logic                ring_q, ring_d;
  logic [7:0]          ring_cnt_q, ring_cnt_d;
  logic [SNOOZE_W-1:0] snooze_cnt_q, snooze_cnt_d;
  logic                missed_q, missed_d;
  logic                missed_set;

  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         rd_mux;

  // Only waddr/raddr[3:2] select a register and wdata[31:24] is never stored.
  logic                unused_bits;
  assign unused_bits = ^{waddr, raddr, wdata[31:24]};

  always_comb begin
    en_d         = en_q;
    ring_to_d    = ring_to_q;
    alarm_time_d = alarm_time_q;
    snooze_len_d = snooze_len_q;
    snz_req_d    = 1'b0;
    dis_req_d    = 1'b0;
    mclr_req_d   = 1'b0;
    if (wr) begin
      case (waddr[3:2])
        A_CTRL: begin
          en_d       = wdata[0];
          snz_req_d  = wdata[1];
          dis_req_d  = wdata[2];
          mclr_req_d = wdata[3];
          ring_to_d  = wdata[15:8];
        end
        A_ALARM:  alarm_time_d = wdata[23:0];
        A_SNZLEN: snooze_len_d = wdata[SNOOZE_W-1:0];
        default: ;
      endcase
    end
  end

  // Commands are seen by the FSM one cycle after the write edge, so a same-cycle
  // ALARM_TIME write never affects a match on that cycle's tick.
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_set   = 1'b0;
    if (!en_q) begin
      state_d      = S_IDLE;
      ring_cnt_d   = 8'd0;
      snooze_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED: begin
          if (sec_tick && (time_bcd == alarm_time_q)) begin
            state_d    = S_RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        S_RINGING: begin
          if (dis_req_q) begin
            state_d = S_ARMED;
          end else if (snz_req_q && (snooze_len_q != '0)) begin
            state_d      = S_SNOOZE;
            snooze_cnt_d = snooze_len_q;
          end else if ((ring_to_q != 8'd0) && (ring_cnt_q >= ring_to_q)) begin
            state_d    = S_ARMED;
            missed_set = 1'b1;
          end else if (sec_tick && (ring_cnt_q != 8'hFF)) begin
            ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end
        S_SNOOZE: begin
          if (dis_req_q) begin
            state_d = S_ARMED;
          end else if (sec_tick) begin
            if (snooze_cnt_q <= SNOOZE_W'(1)) begin
              state_d      = S_RINGING;
              snooze_cnt_d = '0;
              ring_cnt_d   = 8'd0;
            end else begin
              snooze_cnt_d = snooze_cnt_q - SNOOZE_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ring_d   = (state_q == S_RINGING);
    missed_d = missed_q;
    if (mclr_req_q) missed_d = 1'b0;
    if (missed_set) missed_d = 1'b1;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (raddr[3:2])
      A_CTRL:   rd_mux = {16'd0, ring_to_q, 7'd0, en_q};
      A_ALARM:  rd_mux = {8'd0, alarm_time_q};
      A_SNZLEN: rd_mux[SNOOZE_W-1:0] = snooze_len_q;
      A_STATUS: begin
        rd_mux[1:0]            = state_q;
        rd_mux[2]              = ring_q;
        rd_mux[3]              = missed_q;
        rd_mux[15:8]           = ring_cnt_q;
        rd_mux[16 +: SNOOZE_W] = snooze_cnt_q;
      end
      default: ;
    endcase
    rdata_d = rd ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q         <= 1'b0;
      ring_to_q    <= 8'd0;
      alarm_time_q <= 24'd0;
      snooze_len_q <= '0;
      snz_req_q    <= 1'b0;
      dis_req_q    <= 1'b0;
      mclr_req_q   <= 1'b0;
      state_q      <= S_IDLE;
      ring_q       <= 1'b0;
      ring_cnt_q   <= 8'd0;
      snooze_cnt_q <= '0;
      missed_q     <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      en_q         <= en_d;
      ring_to_q    <= ring_to_d;
      alarm_time_q <= alarm_time_d;
      snooze_len_q <= snooze_len_d;
      snz_req_q    <= snz_req_d;
      dis_req_q    <= dis_req_d;
      mclr_req_q   <= mclr_req_d;
      state_q      <= state_d;
      ring_q       <= ring_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      missed_q     <= missed_d;
      rdata_q      <= rdata_d;
    end
  end

  assign rdata       = rdata_q;
  assign ring        = ring_q;
  assign alarm_state = state_q;

endmodule
